// File: rtl/rf_pkg.sv
// Shared types and constants for the parametrised register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;

  // LSB position of lane `port` inside a packed bus of `width`-bit lanes.
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Zeroing sweep sequencer: walks every entry once after reset or on clear_req,
// then parks in RUN until the next request.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (cnt == LAST) begin
            state <= RF_RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        RF_RUN: begin
          if (clear_req) begin
            state <= RF_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= RF_CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we  = busy;
  assign clr_idx = cnt;

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with a self-clearing sweep.
// Build macro RF_BYPASS_EN: forward same-cycle accepted writes into reads.
module param_register_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ok,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_acc;
  logic              wr_keep;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [ADDR_W-1:0] rd_sel  [NUM_RD];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic [DATA_W-1:0] rd_q    [NUM_RD];

  rf_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // A write is accepted only in RUN and loses to a simultaneous clear request.
  assign wr_acc  = !busy && wr_en && !clear_req;
  assign wr_keep = wr_acc && !((ZERO_REG != 0) && (wr_idx == '0));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_keep) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ok <= 1'b0;
    end else begin
      wr_ok <= wr_acc;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign rd_sel[g]                                = rd_idx[slice_lsb(g, ADDR_W) +: ADDR_W];
    assign rd_data[slice_lsb(g, DATA_W) +: DATA_W] = rd_q[g];
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_next[p] = mem[rd_sel[p]];
`ifdef RF_BYPASS_EN
      if (wr_keep && (wr_idx == rd_sel[p])) begin
        rd_next[p] = wr_data;
      end
`endif
      if ((ZERO_REG != 0) && (rd_sel[p] == '0)) begin
        rd_next[p] = '0;
      end
    end
  end

  // Disabled or blocked ports hold their last data and drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= '0;
      end
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (!busy && rd_en[p]) begin
          rd_q[p]     <= rd_next[p];
          rd_valid[p] <= 1'b1;
        end else begin
          rd_valid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed, scoreboard-checked bench for param_register_file (2-port and 4-port builds).
module tb_param_register_file;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clear_req, busy, wr_en, wr_ok;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [1:0]  rd_en, rd_valid;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;

  logic         c4_clear_req, c4_busy, c4_wr_en, c4_wr_ok;
  logic [4:0]   c4_wr_idx;
  logic [31:0]  c4_wr_data;
  logic [3:0]   c4_rd_en, c4_rd_valid;
  logic [19:0]  c4_rd_idx;
  logic [127:0] c4_rd_data;

  param_register_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ok(wr_ok),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  param_register_file #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)
  ) u_dut4 (
    .clk(clk), .rst(rst), .clear_req(c4_clear_req), .busy(c4_busy),
    .wr_en(c4_wr_en), .wr_idx(c4_wr_idx), .wr_data(c4_wr_data), .wr_ok(c4_wr_ok),
    .rd_en(c4_rd_en), .rd_idx(c4_rd_idx), .rd_data(c4_rd_data), .rd_valid(c4_rd_valid)
  );

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d0;
    logic [1:0]  v;
    logic        ok;
    logic        bsy;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] sb4[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [32];
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_rd  [2];

  logic [4:0]  idx4 [4];
  logic [31:0] val4 [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_idx    = '0;
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    rd_en  = 2'b11;
    rd_idx = {b, a};
  endtask

  task automatic model_reset();
    m_busy  = 1'b1;
    m_cnt   = 0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    sb.delete();
  endtask

  // Predict the post-edge outputs from current inputs, advance one clock, compare.
  task automatic step();
    exp_t       e;
    bit         run, wacc;
    logic [4:0] i;
    run  = !m_busy;
    wacc = run && wr_en && !clear_req;
    e    = '0;
    for (int p = 0; p < 2; p++) begin
      i = rd_idx[p*5 +: 5];
      if (run && rd_en[p]) begin
        if (i == 5'd0)                      m_rd[p] = 32'h0;
        else if (BYP && wacc && wr_idx == i) m_rd[p] = wr_data;
        else                                 m_rd[p] = mem_m[i];
        e.v[p] = 1'b1;
      end
    end
    e.d0 = m_rd[0];
    e.d1 = m_rd[1];
    e.ok = wacc;
    if (m_busy) begin
      mem_m[m_cnt] = '0;
      if (m_cnt == 31) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (wacc && wr_idx != 5'd0) mem_m[wr_idx] = wr_data;
      if (clear_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    e.bsy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rd_data0", rd_data[31:0], e.d0);
    chk("rd_data1", rd_data[63:32], e.d1);
    chk("rd_valid", 32'(rd_valid), 32'(e.v));
    chk("wr_ok", 32'(wr_ok), 32'(e.ok));
    chk("busy", 32'(busy), 32'(e.bsy));
  endtask

  initial begin
    logic [127:0] e4;
    set_idle();
    c4_clear_req = 1'b0; c4_wr_en = 1'b0; c4_wr_idx = '0; c4_wr_data = '0;
    c4_rd_en = '0; c4_rd_idx = '0;
    for (int k = 0; k < 32; k++) mem_m[k] = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_wr_ok", 32'(wr_ok), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_busy4", 32'(c4_busy), 32'h1);
    rst = 1'b0;

    // Initial sweep: busy for exactly 32 edges.
    repeat (32) step();

    for (int k = 0; k < 32; k++) begin
      rd2(5'(k), 5'(31 - k));
      step();
    end
    set_idle();
    step();

    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    set_idle(); rd2(5'd5, 5'd5);
    step();
    set_idle();
    step();

    wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFFFFFF;
    step();
    set_idle(); rd2(5'd0, 5'd0);
    step();
    set_idle();

    wr_en = 1'b1; wr_idx = 5'd7; wr_data = 32'h12345678; rd2(5'd7, 5'd7);
    step();
    chk("same_cycle_rd7", rd_data[31:0], BYP ? 32'h12345678 : 32'h0);
    set_idle(); rd2(5'd7, 5'd5);
    step();
    set_idle();

    for (int k = 1; k < 32; k++) begin
      wr_en = 1'b1; wr_idx = 5'(k); wr_data = (32'(k) * 32'h01010101) ^ 32'hA5000000;
      step();
    end
    set_idle();

    // Clear request with a colliding write and pre-clear reads.
    clear_req = 1'b1; wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'hCAFEF00D; rd2(5'd3, 5'd9);
    step();
    set_idle();
    for (int k = 0; k < 32; k++) begin
      rd2(5'(k), 5'(31 - k));
      wr_en = 1'b1; wr_idx = 5'(k); wr_data = 32'h5A5A0000 | 32'(k);
      clear_req = (k == 5);
      step();
      set_idle();
    end
    for (int k = 0; k < 32; k++) begin
      rd2(5'(k), 5'(31 - k));
      step();
    end
    set_idle();

    // Reset in the middle of a sweep restarts it.
    for (int k = 1; k < 6; k++) begin
      wr_en = 1'b1; wr_idx = 5'(k); wr_data = 32'h0BAD0000 | 32'(k);
      step();
    end
    set_idle(); rd2(5'd2, 5'd4);
    step();
    set_idle(); clear_req = 1'b1;
    step();
    set_idle();
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("midsweep_rst_busy", 32'(busy), 32'h1);
    chk("midsweep_rst_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("midsweep_rst_rd_valid", 32'(rd_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (32) step();
    for (int k = 0; k < 8; k++) begin
      rd2(5'(k), 5'(k + 8));
      step();
    end
    set_idle();
    step();

    // Four-port build without a hard-wired zero entry.
    chk("c4_busy_idle", 32'(c4_busy), 32'h0);
    idx4[0] = 5'd0;  idx4[1] = 5'd10; idx4[2] = 5'd20; idx4[3] = 5'd31;
    val4[0] = 32'hFFFFFFFF; val4[1] = 32'h10101010; val4[2] = 32'h20202020; val4[3] = 32'h31313131;
    for (int k = 0; k < 4; k++) begin
      c4_wr_en = 1'b1; c4_wr_idx = idx4[k]; c4_wr_data = val4[k];
      @(posedge clk);
      #1;
      chk("c4_wr_ok", 32'(c4_wr_ok), 32'h1);
    end
    c4_wr_en = 1'b0;
    for (int r = 0; r < 2; r++) begin
      c4_rd_en = 4'hF;
      for (int p = 0; p < 4; p++) begin
        c4_rd_idx[p*5 +: 5] = (r == 0) ? idx4[p] : idx4[3 - p];
        e4[p*32 +: 32]      = (r == 0) ? val4[p] : val4[3 - p];
      end
      sb4.push_back(e4);
      @(posedge clk);
      #1;
      e4 = sb4.pop_front();
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("c4_rd_data%0d", p), c4_rd_data[p*32 +: 32], e4[p*32 +: 32]);
      end
      chk("c4_rd_valid", 32'(c4_rd_valid), 32'hF);
      chk("c4_wr_ok_idle", 32'(c4_wr_ok), 32'h0);
    end
    c4_rd_en = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the team's fixed 32x32 register file: DATA_W-wide, 2**ADDR_W-deep storage, NUM_RD independent registered read ports, one write port.
- Adds a self-clearing sweep state machine (after reset and on request), per-port read-valid flags and a write-acknowledge pulse.
- Sits in the CPU datapath between decode (indices) and execute (operands); also usable as a generic scratch memory.

Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..8)
- ZERO_REG, 1, when 1, entry 0 is hard-wired to zero (writes discarded, reads return 0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  one-cycle request to re-zero all entries
- busy  out  1  high while the clear sweep is running
- wr_en  in  1  write request
- wr_idx  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- wr_ok  out  1  registered pulse: previous-cycle write accepted
- rd_en  in  NUM_RD  per-port read enable
- rd_idx  in  NUM_RD*ADDR_W  packed read indices, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_valid  out  NUM_RD  per-port: rd_data updated by a read last cycle

Behaviour:
- rst asserted, asynchronously:
  - rd_data all 0, rd_valid 0, wr_ok 0
  - busy 1, FSM = CLEAR, sweep counter 0
  - Array contents are not reset directly; the sweep clears them.
- FSM states CLEAR and RUN:
  - CLEAR: each cycle writes 0 to entry[cnt], then cnt++.
  - When cnt == DEPTH-1, that entry is written and the next state is RUN.
  - The sweep takes exactly DEPTH cycles; busy falls on the edge that enters RUN.
- RUN + clear_req=1: next state CLEAR, cnt=0, busy=1 next cycle. clear_req during CLEAR is ignored (no restart).
- Write, RUN only:
  - wr_en=1 and clear_req=0: entry[wr_idx] <= wr_data at the edge; wr_ok=1 the next cycle.
  - With ZERO_REG=1 and wr_idx=0: data is discarded but wr_ok still pulses.
  - Writes in CLEAR, or with clear_req=1 in the same cycle, are dropped: wr_ok=0, no update.
- Read, per port p, 1-cycle latency:
  - RUN and rd_en[p]=1: rd_data[p] <= entry[rd_idx[p]], rd_valid[p] <= 1.
  - rd_en[p]=0 or state CLEAR: rd_data[p] holds its previous value (no tri-state), rd_valid[p] <= 0.
  - ZERO_REG=1 and rd_idx=0: rd_data[p] <= 0.
- A read in the same cycle as clear_req returns pre-clear data with valid=1.
- Multiple ports reading the same index: all get identical data.
- Read and write to the same index in the same cycle: the read returns the OLD value (see Optional Feature).
- Reset mid-sweep: the sweep restarts from 0. Reset mid-RUN: entries keep their contents until the sweep overwrites them.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a same-cycle accepted write to an index being read forwards wr_data into rd_data[p]. This is write-first behaviour.
  - No forwarding when the write is dropped.
  - No forwarding for index 0 when ZERO_REG=1.
- Undefined: read-first; the old entry value is returned.

Decomposition:
- Package rf_pkg: state enum rf_state_t {RF_CLEAR, RF_RUN}; default width constants; a helper function for packed-slice extraction.
- Sub-module rf_clear_fsm:
  - Inputs: clk, rst, clear_req.
  - Outputs: busy, clr_we, clr_idx[ADDR_W].
  - The storage array and read/write ports stay in the top module.

Test Plan:
- Reset, then idle with defaults → busy high exactly 32 cycles after rst falls; all reads then return 0x00000000 with rd_valid=1.
- Write idx 5 = 0xDEADBEEF; next cycle read idx 5 on both ports → rd_data = 0xDEADBEEF on both, rd_valid=11, wr_ok pulsed once.
- Write idx 0 = 0xFFFFFFFF, then read idx 0 → 0x00000000 with wr_ok=1. Repeat with ZERO_REG=0 → 0xFFFFFFFF.
- Same-cycle write idx 7 = 0x12345678 (old 0x0) with read idx 7:
  - RF_BYPASS_EN undefined → 0x00000000.
  - RF_BYPASS_EN defined → 0x12345678.
- Fill idx 1..31, then pulse clear_req together with a write to idx 3:
  - wr_ok=0; busy high 32 cycles; reads during the sweep give rd_valid=0 and held data.
  - Afterwards all entries read 0.
- Assert rst at sweep cycle 10 → busy stays high and completes 32 cycles after the new deassertion. NUM_RD=4 build: four ports read distinct indices concurrently → each gets the correct value.
